mem_responder: RTL and testbench



---
 rtl/mem_if_pkg.sv | 14 +
 rtl/mem_line_array.sv | 35 +++
 rtl/mem_responder.sv | 100 ++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Widths and FSM encodings for the cache-to-memory line interface.
// The cache imports this package as well, so both sides agree on the widths.
package mem_if_pkg;

  localparam int MEM_ADDR_W = 28;
  localparam int MEM_LINE_W = 128;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: DEPTH x 128, synchronous write, registered read, one access port.
// The storage array itself has no reset, so it can map onto block RAM.
module mem_line_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [MEM_LINE_W-1:0] wdata,
  output logic [MEM_LINE_W-1:0] rdata
);

  logic [MEM_LINE_W-1:0] lines [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      lines[idx] <= wdata;
    end
  end

  // Output register holds the last read line; writes leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= lines[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one line read/write per handshake, fixed latency,
// one-cycle registered mem_ready pulse.
//
// state | meaning
// IDLE  | sample mem_read/mem_write; capture the request when either is high
// BUSY  | count down LATENCY-1..0, inputs ignored; access the array on exit
// DONE  | mem_ready high for this cycle; return to IDLE without sampling
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [MEM_LINE_W-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic [MEM_LINE_W-1:0] mem_rdata,
  output logic                  proto_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  cap_write;
  logic [IDX_W-1:0]      cap_idx;
  logic [MEM_LINE_W-1:0] cap_wdata;
  logic                  access;
  logic                  unused_addr_hi;

  // Upper address bits alias modulo DEPTH.
  assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:IDX_W];

  assign access = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      mem_ready <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            state     <= BUSY;
            cnt       <= CNT_LOAD;
            // Read wins a collision; the write data is dropped.
            cap_write <= mem_write && !mem_read;
            cap_idx   <= mem_addr[IDX_W-1:0];
            cap_wdata <= mem_wdata;
            if (mem_read && mem_write) begin
              proto_err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state     <= DONE;
            mem_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage is touched only on the BUSY->DONE edge, so a reset mid-BUSY
  // never modifies a line.
  mem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_lines (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (access),
    .we    (cap_write),
    .idx   (cap_idx),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for the short-latency reset case.
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         rd0 = 1'b0, wr0 = 1'b0;
  logic [27:0]  addr0 = '0;
  logic [127:0] wd0 = '0;
  logic         rdy0, perr0;
  logic [127:0] rdata0;

  logic         rd1 = 1'b0, wr1 = 1'b0;
  logic [27:0]  addr1 = '0;
  logic [127:0] wd1 = '0;
  logic         rdy1, perr1;
  logic [127:0] rdata1;

  int n_cmp = 0;
  int n_err = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  int lat;
  int base;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_03 = {16{8'h03}};
  localparam logic [127:0] PAT_20 = {4{32'h2020_0020}};
  localparam logic [127:0] PAT_21 = {4{32'h2121_0021}};
  localparam logic [127:0] PAT_05 = {4{32'h0505_0005}};
  localparam logic [127:0] PAT_06 = {4{32'h0606_0006}};
  localparam logic [127:0] PAT_FF = 128'hFF;

  mem_responder #(.LATENCY(4), .DEPTH(256)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (rd0),
    .mem_write (wr0),
    .mem_addr  (addr0),
    .mem_wdata (wd0),
    .mem_ready (rdy0),
    .mem_rdata (rdata0),
    .proto_err (perr0)
  );

  mem_responder #(.LATENCY(1), .DEPTH(256)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (rd1),
    .mem_write (wr1),
    .mem_addr  (addr1),
    .mem_wdata (wd1),
    .mem_ready (rdy1),
    .mem_rdata (rdata1),
    .proto_err (perr1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy0) pulses0++;
    if (rdy1) pulses1++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] wd);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd;
    end
  endtask

  // i=0 is the negedge just after the capture edge; -1 means no pulse seen.
  task automatic wait_rdy(input int sel, output int l);
    l = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel == 0) ? rdy0 : rdy1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic xfer(input int sel, input logic rd, input logic wr,
                      input logic [27:0] a, input logic [127:0] wd, input string tag);
    int l;
    @(negedge clk);
    drive(sel, rd, wr, a, wd);
    wait_rdy(sel, l);
    chk({tag, "_lat"}, 128'(l), (sel == 0) ? 128'd4 : 128'd1);
    @(negedge clk);
    chk({tag, "_width"}, {127'd0, (sel == 0) ? rdy0 : rdy1}, 128'd0);
    drive(sel, 1'b0, 1'b0, a, wd);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {127'd0, rdy0}, 128'd0);
    chk("rst_rdata", rdata0, 128'd0);
    chk("rst_perr", {127'd0, perr0}, 128'd0);
    rst_n = 1'b1;

    // write then read back
    xfer(0, 1'b0, 1'b1, 28'h0000010, PAT_A5, "wr10");
    xfer(0, 1'b1, 1'b0, 28'h0000010, 128'd0, "rd10");
    chk("rd10_data", rdata0, PAT_A5);

    // aliasing modulo DEPTH
    xfer(0, 1'b0, 1'b1, 28'h0000103, PAT_03, "wr103");
    xfer(0, 1'b1, 1'b0, 28'h0000003, 128'd0, "rd003");
    chk("alias_data", rdata0, PAT_03);
    chk("alias_perr", {127'd0, perr0}, 128'd0);

    // fill then write-back, cache-like timing: read held through DONE
    xfer(0, 1'b0, 1'b1, 28'h0000020, PAT_20, "pre20");
    base = pulses0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 28'h0000020, 128'd0);
    wait_rdy(0, lat);
    chk("fill_lat", 128'(lat), 128'd4);
    chk("fill_data", rdata0, PAT_20);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b1, 28'h0000021, PAT_21);
    @(posedge clk);
    wait_rdy(0, lat);
    chk("wb_lat", 128'(lat), 128'd4);
    chk("wb_rdata_held", rdata0, PAT_20);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 28'h0, 128'd0);
    repeat (8) @(negedge clk);
    chk("fill_wb_pulses", 128'(pulses0 - base), 128'd2);
    xfer(0, 1'b1, 1'b0, 28'h0000021, 128'd0, "rd21");
    chk("wb_commit", rdata0, PAT_21);

    // address change while BUSY is ignored
    xfer(0, 1'b0, 1'b1, 28'h0000005, PAT_05, "wr5");
    xfer(0, 1'b0, 1'b1, 28'h0000006, PAT_06, "wr6");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 28'h0000005, 128'd0);
    @(negedge clk);
    addr0 = 28'h0000006;
    wait_rdy(0, lat);
    chk("chg_lat", 128'(lat), 128'd3);
    chk("chg_data", rdata0, PAT_05);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 28'h0, 128'd0);

    // read+write collision: read wins, write dropped, sticky error
    xfer(0, 1'b0, 1'b1, 28'h0000007, 128'h1, "wr7");
    xfer(0, 1'b1, 1'b1, 28'h0000007, 128'h2, "rw7");
    chk("coll_data", rdata0, 128'h1);
    chk("coll_perr", {127'd0, perr0}, 128'd1);
    xfer(0, 1'b1, 1'b0, 28'h0000007, 128'd0, "rd7");
    chk("coll_keep", rdata0, 128'h1);
    chk("coll_perr_sticky", {127'd0, perr0}, 128'd1);

    // reset mid-BUSY aborts a write
    xfer(0, 1'b0, 1'b1, 28'h0000009, 128'h0, "wr9_0");
    base = pulses0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 28'h0000009, PAT_FF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 28'h0, 128'd0);
    #1;
    chk("abort_ready", {127'd0, rdy0}, 128'd0);
    chk("abort_rdata", rdata0, 128'd0);
    chk("abort_perr", {127'd0, perr0}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_pulses", 128'(pulses0 - base), 128'd0);
    xfer(0, 1'b1, 1'b0, 28'h0000009, 128'd0, "rd9");
    chk("abort_no_commit", rdata0, 128'h0);

    // LATENCY=1 instance
    xfer(1, 1'b0, 1'b1, 28'h0000009, PAT_FF, "l1_wr9");
    xfer(1, 1'b1, 1'b0, 28'h0000009, 128'd0, "l1_rd9");
    chk("l1_data", rdata1, PAT_FF);
    xfer(1, 1'b0, 1'b1, 28'h0000009, 128'h0, "l1_wr9_0");
    base = pulses1;
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 28'h0000009, PAT_FF);
    @(posedge clk);
    #1 rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 28'h0, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("l1_abort_pulses", 128'(pulses1 - base), 128'd0);
    xfer(1, 1'b1, 1'b0, 28'h0000009, 128'd0, "l1_rd9b");
    chk("l1_abort_no_commit", rdata1, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
